// File: rtl/sha256_pkg.sv
// Shared SHA-256 front-end definitions.
// Contents:
//   SHA256_PAD_BYTE      - first padding byte appended after the message
//   SHA256_MAX_MSG_BYTES - largest single-block message this front end handles
//   SHA256_BLOCK_WORDS   - message words w0..w14 supplied to the core (w15 is the length)
//   packer_state_e       - packer FSM states
//   sha256_insert_byte   - big-endian byte-lane insertion into a 32-bit word
package sha256_pkg;

    localparam logic [7:0]  SHA256_PAD_BYTE      = 8'h80;
    localparam int unsigned SHA256_MAX_MSG_BYTES = 31;
    localparam int unsigned SHA256_BLOCK_WORDS   = 15;

    typedef enum logic {
        COLLECT,
        HOLD
    } packer_state_e;

    // Lane 0 is the most significant byte: message byte k lands in lane k%4.
    function automatic logic [31:0] sha256_insert_byte(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic [7:0]  data
    );
        logic [31:0] r;
        r = word;
        case (lane)
            2'd0:    r[31:24] = data;
            2'd1:    r[23:16] = data;
            2'd2:    r[15:8]  = data;
            default: r[7:0]   = data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sha256_msg_packer.sv
// sha256_msg_packer
// Packs an AXI-Stream byte stream (one byte per beat) big-endian into a
// single SHA-256 block (w0..w14), appends the 0x80 pad byte, reports the
// message length in bits and hands the block to the core with a
// valid/ready handshake. Input is blocked while a block is held.
// Ports:
//   m_axis_aclk, m_axis_aresetn       - clock, async active-low reset
//   s_axis_tvalid/tready/tdata/tkeep/tlast - byte input (tdata[7:0], tkeep[0])
//   string_w0..string_w14             - packed, padded block words
//   string_size                       - message length in bits
//   string_dv, string_ready           - block handshake to the core
//   msg_overflow                      - message was truncated to MAX_BYTES
module sha256_msg_packer
    import sha256_pkg::*;
#(
    parameter int unsigned MAX_BYTES = SHA256_MAX_MSG_BYTES
) (
    input  logic        m_axis_aclk,
    input  logic        m_axis_aresetn,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [31:0] s_axis_tdata,
    input  logic [3:0]  s_axis_tkeep,
    input  logic        s_axis_tlast,
    output logic [31:0] string_w0,
    output logic [31:0] string_w1,
    output logic [31:0] string_w2,
    output logic [31:0] string_w3,
    output logic [31:0] string_w4,
    output logic [31:0] string_w5,
    output logic [31:0] string_w6,
    output logic [31:0] string_w7,
    output logic [31:0] string_w8,
    output logic [31:0] string_w9,
    output logic [31:0] string_w10,
    output logic [31:0] string_w11,
    output logic [31:0] string_w12,
    output logic [31:0] string_w13,
    output logic [31:0] string_w14,
    output logic [7:0]  string_size,
    output logic        string_dv,
    input  logic        string_ready,
    output logic        msg_overflow
);

    // MAX_BYTES <= 31, so the byte count and the pad position fit in 5 bits.
    localparam int unsigned          CNT_W   = 5;
    localparam logic [CNT_W-1:0]     MAX_CNT = CNT_W'(MAX_BYTES);

    packer_state_e     state_q;
    logic [31:0]       words_q [SHA256_BLOCK_WORDS];
    logic [31:0]       words_d [SHA256_BLOCK_WORDS];
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              trunc_q;
    logic [7:0]        size_q;
    logic [7:0]        size_d;
    logic              dv_q;
    logic              ovf_q;
    logic              tready_q;

    logic              beat;
    logic              store;
    logic              discard;

    // Only the low byte and tkeep[0] carry information.
    logic unused_inputs;
    assign unused_inputs = ^{s_axis_tdata[31:8], s_axis_tkeep[3:1]};

    assign beat    = s_axis_tvalid && tready_q;
    assign store   = beat && s_axis_tkeep[0] && (count_q < MAX_CNT);
    assign discard = beat && s_axis_tkeep[0] && (count_q >= MAX_CNT);

    // Next block contents: the accepted byte (if stored) and, on tlast, the
    // pad byte right behind it. Both may land in the same word in one cycle.
    always_comb begin
        words_d = words_q;
        count_d = count_q + {{(CNT_W-1){1'b0}}, store};
        if (store) begin
            words_d[count_q[CNT_W-1:2]] = sha256_insert_byte(
                words_d[count_q[CNT_W-1:2]], count_q[1:0], s_axis_tdata[7:0]);
        end
        if (beat && s_axis_tlast) begin
            words_d[count_d[CNT_W-1:2]] = sha256_insert_byte(
                words_d[count_d[CNT_W-1:2]], count_d[1:0], SHA256_PAD_BYTE);
        end
        size_d = {count_d, 3'b000};
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            state_q  <= COLLECT;
            words_q  <= '{default: '0};
            count_q  <= '0;
            trunc_q  <= 1'b0;
            size_q   <= '0;
            dv_q     <= 1'b0;
            ovf_q    <= 1'b0;
            tready_q <= 1'b1;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (beat) begin
                        words_q <= words_d;
                        count_q <= count_d;
                        if (s_axis_tlast) begin
                            size_q   <= size_d;
                            ovf_q    <= trunc_q | discard;
                            trunc_q  <= 1'b0;
                            dv_q     <= 1'b1;
                            tready_q <= 1'b0;
                            state_q  <= HOLD;
                        end else begin
                            trunc_q  <= trunc_q | discard;
                        end
                    end
                end
                HOLD: begin
                    if (string_ready) begin
                        words_q  <= '{default: '0};
                        count_q  <= '0;
                        trunc_q  <= 1'b0;
                        size_q   <= '0;
                        ovf_q    <= 1'b0;
                        dv_q     <= 1'b0;
                        tready_q <= 1'b1;
                        state_q  <= COLLECT;
                    end
                end
                default: begin
                    state_q  <= COLLECT;
                    tready_q <= 1'b1;
                    dv_q     <= 1'b0;
                end
            endcase
        end
    end

    assign s_axis_tready = tready_q;
    assign string_dv     = dv_q;
    assign string_size   = size_q;
    assign msg_overflow  = ovf_q;

    assign string_w0  = words_q[0];
    assign string_w1  = words_q[1];
    assign string_w2  = words_q[2];
    assign string_w3  = words_q[3];
    assign string_w4  = words_q[4];
    assign string_w5  = words_q[5];
    assign string_w6  = words_q[6];
    assign string_w7  = words_q[7];
    assign string_w8  = words_q[8];
    assign string_w9  = words_q[9];
    assign string_w10 = words_q[10];
    assign string_w11 = words_q[11];
    assign string_w12 = words_q[12];
    assign string_w13 = words_q[13];
    assign string_w14 = words_q[14];

endmodule

// File: doc/sha256_msg_packer.md
# sha256_msg_packer

Upstream front end for `sha256_core_pif`. It accepts a message as an AXI-Stream byte stream, one byte per beat, and packs it big-endian into the fifteen 32-bit words `string_w0..string_w14`. It appends the 0x80 padding byte and reports the message length in bits. It then presents the packed single block to the core with a valid/ready handshake, and blocks input until the core takes it.

## Interface
- `MAX_BYTES`, default 31: maximum message length in bytes; legal range 1..31, bounded by the 8-bit `string_size`.
- `m_axis_aclk` in 1: the single clock.
- `m_axis_aresetn` in 1: reset; asynchronous, active-low.
- `s_axis_tvalid` in 1: input beat valid.
- `s_axis_tready` out 1: input ready.
- `s_axis_tdata` in 32: message byte in `[7:0]`; `[31:8]` ignored.
- `s_axis_tkeep` in 4: only `[0]` is used; 0 marks a beat with no byte.
- `s_axis_tlast` in 1: last beat of the message.
- `string_w0` .. `string_w14` out 32 each: packed, padded block words.
- `string_size` out 8: message length in bits (bytes × 8).
- `string_dv` out 1: block valid.
- `string_ready` in 1: core accepts the block.
- `msg_overflow` out 1: the message exceeded `MAX_BYTES` and was truncated; valid while `string_dv` is high.

## Operation
- **States.** The FSM has two states, COLLECT and HOLD.
- **Reset.** Enters COLLECT. Byte counter is 0. All `string_w*` are 0, `string_size` is 0, `string_dv`/`msg_overflow` are 0, and `s_axis_tready` is 1.
- **COLLECT.**
  - `s_axis_tready` = 1.
  - A beat is accepted on a clock edge where `tvalid` && `tready`.
  - If `tkeep[0]` = 1 and count < `MAX_BYTES`: byte k goes to word k/4, bits `[31-8*(k%4) -: 8]`, and the count increments.
  - If `tkeep[0]` = 1 and count = `MAX_BYTES`: the byte is discarded and the overflow flag is set.
  - A `tkeep[0]` = 0 beat stores nothing, but its `tlast` is still honoured.
- **Accepted beat with `tlast`.**
  - The final byte count n includes that beat's byte, if it was stored.
  - Write 0x80 at byte position n.
  - Set `string_size` = n×8.
  - Go to HOLD.
- **HOLD.**
  - `string_dv` = 1 and `s_axis_tready` = 0.
  - All block outputs are stable.
- **Leaving HOLD.** On the clock edge where `string_ready` = 1:
  - The transfer completes.
  - Words, count, size and overflow are cleared.
  - The FSM returns to COLLECT.
- **Unwritten bytes** of the block are always 0. The length word (w15) is the core's responsibility.
- **Empty message** (`tlast` with no stored byte): n = 0, `string_w0` = 0x80000000, `string_size` = 0.

## Timing
- **Output latency:** `string_dv` rises in the cycle after the edge that accepts the `tlast` beat, i.e. 1 cycle.
- **Handshake:** `string_dv` is never dropped without `string_ready`. `string_ready` is don't-care while `string_dv` = 0.
- **Back-to-back:** `s_axis_tready` returns to 1 in the cycle after the transfer edge. Minimum inter-message gap is 1 idle input cycle plus the HOLD time.
- **Throughput:** one byte per clock in COLLECT, with no internal stalls.
- **Reset mid-message or mid-HOLD:** the partial or held block is discarded and all outputs return to their reset values asynchronously.
- **Overflow:** after truncation, the 0x80 byte is placed at position `MAX_BYTES`. `msg_overflow` = 1 for the whole HOLD.
- **`MAX_BYTES` = 31:** the last byte and the pad byte both land in w7. w8..w14 are always 0.

## Structure
- **Package `sha256_pkg`:**
  - `SHA256_PAD_BYTE` = 8'h80.
  - `SHA256_MAX_MSG_BYTES` = 31.
  - Packer state enum (COLLECT, HOLD).
  - Block word count 15.
- The block is a single module with no sub-module. Byte-lane insertion is a function in the package, shared with future multi-block packers.
- Storage is an internal array of 15 × 32-bit words mapped onto the output ports.

## Test plan
- **"hola caracola"** (13 bytes, `tlast` on the 13th) → w0 686f6c61, w1 20636172, w2 61636f6c, w3 61800000, w4..w14 0, size 104, overflow 0.
- **"adios"** (61 64 69 6f 73) → w0 6164696f, w1 73800000, rest 0, size 40. Then hold `string_ready` low for 10 cycles: `tready` = 0 and outputs stable. Then pulse `string_ready`: `string_dv` falls and `tready` = 1 in the next cycle.
- **Empty message** (single beat, `tkeep` = 0, `tlast` = 1) → w0 80000000, size 0. Also insert a mid-message `tkeep` = 0 beat into "ab"+"c" → w0 61626380, size 24.
- **31 × 0x61** → w0..w6 61616161, w7 61616180, size 248, overflow 0. **40 × 0x61** → same words and size, overflow 1, and `tready` stays 1 throughout input.
- **Assert `m_axis_aresetn` low** after 6 bytes, then during HOLD → outputs 0 immediately. A following "adios" packs exactly as in the second scenario, with no residue.
- **Back-to-back "hola" then "adios"** with `string_ready` tied 1 → two single-cycle `string_dv` pulses: w0 686f6c61 / w1 80000000 / size 32, then the "adios" block.
